// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between an RV32 core and a word-wide memory port.
// Checks funct3 and alignment, builds the lane strobes and data, formats load data and times out a stuck access.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic [1:0]  o_resp_err,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_MEM  | memory access outstanding, waiting for ack or timeout
  // S_RESP | one-cycle response to the core
  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  // Last MEM cycle index before the counter would reach 255.
  localparam logic [7:0] TMO_LAST    = 8'd254;

  state_t      r_state, w_state_nxt;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;

  logic        w_legal;
  logic        w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic        w_timeout;

  always_comb begin
    w_legal = 1'b0;
    if (i_req_store)
      w_legal = (i_req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      w_legal = (i_req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_misal = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
              ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0 before extending.
  assign w_shifted = i_mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = i_mem_rdata;
    case (r_funct3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'b0, w_shifted[7:0]};
      3'b101:  w_load = {16'b0, w_shifted[15:0]};
      default: w_load = i_mem_rdata;
    endcase
  end

  assign w_timeout = (r_cnt == TMO_LAST) && !i_mem_ack;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_req_valid) w_state_nxt = (!w_legal || w_misal) ? S_RESP : S_MEM;
      S_MEM:  if (i_mem_ack || w_timeout) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'b0;
      r_wdata  <= 32'b0;
      r_cnt    <= 8'd0;
      r_rdata  <= 32'b0;
      r_err    <= ERR_OK;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_store  <= i_req_store;
          r_funct3 <= i_req_funct3;
          r_addr   <= i_req_addr;
          r_wdata  <= i_req_wdata;
          r_cnt    <= 8'd0;
          r_rdata  <= 32'b0;
          if (!w_legal)     r_err <= ERR_FUNCT3;
          else if (w_misal) r_err <= ERR_MISALGN;
          else              r_err <= ERR_OK;
        end
        S_MEM: begin
          if (i_mem_ack) begin
            r_rdata <= r_store ? 32'b0 : w_load;
            r_err   <= ERR_OK;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout) begin
              r_rdata <= 32'b0;
              r_err   <= ERR_TIMEOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE) && i_rst_n;
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_mem_en     = (r_state == S_MEM);
  assign o_mem_we     = (r_state == S_MEM) && r_store;
  assign o_mem_be     = (r_state == S_MEM) ? w_be : 4'b0000;
  assign o_mem_addr   = {r_addr[31:2], 2'b00};
  assign o_mem_wdata  = w_wdata;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 req_valid  in  1  core presents an access request.
REQ-004 req_ready  out  1  unit accepts a request; asserted only in IDLE.
REQ-005 req_store  in  1  1 = store, 0 = load.
REQ-006 req_funct3  in  3  RISC-V funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-007 req_addr  in  32  byte address (ALU result).
REQ-008 req_wdata  in  32  store data (rs2).
REQ-009 resp_valid  out  1  one-cycle response pulse.
REQ-010 resp_rdata  out  32  formatted load data; 0 for stores and errors.
REQ-011 resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-012 mem_en  out  1  memory request strobe.
REQ-013 mem_we  out  1  memory write.
REQ-014 mem_addr  out  32  word address, {req_addr[31:2], 2'b00}.
REQ-015 mem_be  out  4  byte enables, bit i = byte lane i.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_ack  in  1  memory completion; mem_rdata valid when high on a load.
REQ-018 mem_rdata  in  32  raw memory word.

Function
REQ-019 FSM states IDLE, MEM, RESP; exactly one active per cycle.
REQ-020 IDLE: req_ready=1; req_valid=1 latches store, funct3, addr, wdata at the edge.
REQ-021 Illegal funct3: loads other than 000/001/010/100/101; stores other than 000/001/010 -> RESP with err=10, no memory access.
REQ-022 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0 -> RESP with err=01, no memory access; illegal funct3 takes priority.
REQ-023 Legal aligned request -> MEM next cycle.
REQ-024 MEM: mem_en=1; mem_we, mem_addr, mem_be, mem_wdata held stable until mem_ack.
REQ-025 mem_ack while in MEM (including the first MEM cycle) -> RESP next cycle; mem_ack outside MEM ignored.
REQ-026 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}; SW be=4'b1111, wdata unchanged.
REQ-027 Loads drive mem_be per REQ-026 pattern, mem_we=0.
REQ-028 Load format: byte/half selected from mem_rdata by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; captured on the ack edge.
REQ-029 Timeout: 8-bit counter cleared on MEM entry, +1 per MEM cycle without ack; reaching 255 without ack -> RESP with err=11, rdata=0; ack in the same cycle wins (err=00).
REQ-030 RESP: resp_valid=1 exactly one cycle, resp_rdata/resp_err valid, req_ready=0; -> IDLE next cycle.
REQ-031 Best-case latency: accept at edge N, mem_en high in cycle N+1, ack in N+1, resp_valid in N+2, req_ready again in N+3; error paths: resp_valid in N+1.
REQ-032 req_valid outside IDLE ignored; the core holds the request until resp_valid.
REQ-033 mem_en, mem_we, mem_be are 0 outside MEM.

Reset
REQ-034 rst_n=0 at an edge -> state IDLE, counter 0, resp_valid=0, resp_rdata=0, resp_err=00, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; req_ready=0 while rst_n=0, 1 in the first cycle after release.
REQ-035 Reset mid-MEM aborts the transaction: mem_en low after that edge, no response issued, later ack ignored.

Verification
REQ-036 LB addr=0x103, mem_rdata=0x80FF_1234, ack in first MEM cycle -> mem_addr=0x100, be=1000, resp_rdata=0xFFFF_FF80, err=00, resp_valid 2 cycles after accept.
REQ-037 SH addr=0x202, wdata=0xAAAA_BEEF -> mem_we=1, be=1100, mem_wdata=0xBEEF_BEEF, resp_rdata=0, err=00.
REQ-038 LW addr=0x006 -> no mem_en, resp_valid next cycle, err=01; LBU funct3 store=1 (100) -> err=10.
REQ-039 LHU addr=0x002, mem_ack withheld -> err=11 after 255 MEM cycles; repeat with ack on cycle 255 -> err=00, rdata zero-extended upper half.
REQ-040 Reset asserted during MEM with ack 3 cycles later -> mem_en 0 after reset edge, no resp_valid, req_ready=1 after release; next LW completes normally.
